fec_cc_tb_encoder: RTL
======================

Name: fec_cc_tb_encoder

Overview:
- Tail-biting convolutional encoder: rate 1/2, constraint length K=7, generators G1=171 and G2=133 (octal).
- Sits directly downstream of the PRBS randomizer and consumes its serial DataOut stream one bit per cycle.
- Buffers one full FEC block, since tail-biting needs the last 6 bits before encoding starts.
- Emits one (X,Y) coded pair per cycle to the interleaver stage.

Parameters:
- BLOCK_LEN, 96, uncoded bits per FEC block (legal range 7..1024).
- CNT_W, 10, width of the block bit counter; must satisfy 2^CNT_W >= BLOCK_LEN.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bit  input  1  randomized data bit; first bit of the block arrives first (MSB-first).
- in_valid  input  1  in_bit is valid.
- in_last  input  1  marks the final bit of a block; qualified by in_valid.
- in_ready  output  1  encoder can accept a bit.
- out_x  output  1  coded bit X (G1).
- out_y  output  1  coded bit Y (G2).
- out_valid  output  1  out_x/out_y are valid.
- out_last  output  1  marks the final pair of a block.
- out_ready  input  1  downstream accepts the pair.
- err_len  output  1  sticky block-length error.

Behaviour:
- Reset (rst_n=0, async):
  - FSM goes to FILL; counter=0; state register=0.
  - in_ready=0 while in reset, 1 in the first cycle after release.
  - out_valid=0, out_last=0, out_x=0, out_y=0, err_len=0.
  - Buffer contents are don't-care.
- Reset asserted mid-block discards the partial block and any pending output. No pair may be emitted after rst_n rises until a new full block has been accepted.
- Handshakes: input transfer = in_valid&in_ready; output transfer = out_valid&out_ready. Outputs hold stable while out_valid=1 and out_ready=0.
- FSM FILL:
  - in_ready=1. On each transfer, buf[cnt]<=in_bit and cnt increments.
  - Transfer with in_last=1 and cnt==BLOCK_LEN-1: go to LOAD.
  - Transfer with in_last=1 and cnt<BLOCK_LEN-1: drop the block, set err_len, cnt<=0, stay in FILL.
  - Transfer with cnt==BLOCK_LEN-1 and in_last=0: set err_len, treat the bit as last, go to LOAD.
- FSM LOAD (1 cycle):
  - in_ready=0.
  - Tail-biting preload: s1<=buf[N-1], s2<=buf[N-2], ..., s6<=buf[N-6], where N=BLOCK_LEN and sk is the input delayed k steps.
  - cnt<=0. Go to ENCODE.
- FSM ENCODE:
  - in_ready=0; out_valid=1. d=buf[cnt].
  - X = d^s1^s2^s3^s6.
  - Y = d^s2^s3^s5^s6.
  - On an output transfer: shift s6<=s5, ..., s2<=s1, s1<=d; cnt increments.
  - out_last=1 when cnt==BLOCK_LEN-1.
  - Transfer with out_last=1: cnt<=0, go to FILL.
- Tail-biting property: after the final shift the state equals the preload value. Verification checks this via an internal assertion.
- Latency: the first pair is valid 2 clocks after the last-bit input transfer (FILL->LOAD->ENCODE).
- Throughput: one block per BLOCK_LEN+1+BLOCK_LEN cycles (no fill/encode overlap).
- err_len is cleared only by reset.
- out_x/out_y are driven combinationally from registered state and buffer: no input-to-output combinational path.

Test Plan:
1. All-zero 96-bit block, out_ready=1 -> 96 pairs all X=0,Y=0; out_last on pair 95; first out_valid 2 cycles after in_last transfer.
2. Impulse: bit0=1, rest 0 -> pairs 0..6 X=1,1,1,1,0,0,1 and Y=1,0,1,1,0,1,1; pairs 7..95 all 0.
3. Wrap-around: only bit95=1 -> pairs 0..5 X=1,1,1,0,0,1 and Y=0,1,1,0,1,1; pair 95 X=1,Y=1; all other pairs 0; final state equals preload.
4. All-ones block -> every pair X=1,Y=1. Randomizer output 0x558AC4A53A1724E163AC2BF9 -> output matches the golden-model G1/G2 tail-biting result bit-exactly.
5. Back-pressure: toggle out_ready 1/0 each cycle and hold in_valid random -> identical pair sequence to scenario 4; no pair duplicated or lost; in_ready=0 throughout LOAD/ENCODE.
6. Errors and reset:
   - in_last on bit 40 -> err_len=1, no output, next 96-bit block encodes correctly.
   - rst_n low at pair 50 -> out_valid=0 immediately, err_len=0, in_ready=1 after release.

Source files
------------

// File: rtl/fec_cc_tb_encoder.sv
// Tail-biting convolutional encoder, rate 1/2, K=7, G1=171 / G2=133 (octal).
// A full block is buffered first because the encoder state must be preloaded
// with the last six bits of the block before the first pair can be produced.
//
// Handshakes: a bit is taken when in_valid && in_ready on a rising edge; a
// pair is taken when out_valid && out_ready on a rising edge. While
// out_valid=1 and out_ready=0, out_x/out_y/out_last hold stable.
module fec_cc_tb_encoder #(
    parameter int BLOCK_LEN = 96,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_x,
    output logic       out_y,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err_len,
    output logic [1:0] dbg_state
);

    localparam int IDX_W  = $clog2(BLOCK_LEN);
    localparam int BUF_SZ = 1 << IDX_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ENCODE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:1]       s_q, s_d;      // s_q[k] = input delayed k steps
    logic [6:1]       pre_q, pre_d;  // preload value, kept for the wrap check
    logic             err_q, err_d;
    logic [BUF_SZ-1:0] buf_q;

    logic       in_xfer;
    logic       out_xfer;
    logic       d_bit;
    logic       x_raw;
    logic       y_raw;
    logic [6:1] preload;
    logic       enc_valid;
    logic       enc_last;

    // Ready only out of reset and while filling; gating with rst_n keeps it low during reset.
    assign in_ready = rst_n && (state_q == ST_FILL);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = enc_valid && out_ready;

    // Current data bit and generator taps, all from registered state and buffer.
    assign d_bit   = buf_q[cnt_q[IDX_W-1:0]];
    assign x_raw   = d_bit ^ s_q[1] ^ s_q[2] ^ s_q[3] ^ s_q[6];
    assign y_raw   = d_bit ^ s_q[2] ^ s_q[3] ^ s_q[5] ^ s_q[6];
    assign preload = {buf_q[BLOCK_LEN-6], buf_q[BLOCK_LEN-5], buf_q[BLOCK_LEN-4],
                      buf_q[BLOCK_LEN-3], buf_q[BLOCK_LEN-2], buf_q[BLOCK_LEN-1]};

    // Outputs are forced to zero outside ENCODE so the buffer's don't-care contents never leak.
    assign out_valid = enc_valid;
    assign out_last  = enc_last;
    assign out_x     = enc_valid & x_raw;
    assign out_y     = enc_valid & y_raw;
    assign err_len   = err_q;
    assign dbg_state = state_q;

    // Next-state logic for the FILL -> LOAD -> ENCODE sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        pre_d     = pre_q;
        err_d     = err_q;
        enc_valid = 1'b0;
        enc_last  = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (in_xfer) begin
                    if (cnt_q == LAST_IDX) begin
                        // A full block ends here even if in_last is missing.
                        state_d = ST_LOAD;
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        // Short block: drop it and start over.
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                s_d     = preload;
                pre_d   = preload;
                cnt_d   = '0;
                state_d = ST_ENCODE;
            end
            ST_ENCODE: begin
                enc_valid = 1'b1;
                enc_last  = (cnt_q == LAST_IDX);
                if (out_xfer) begin
                    s_d = {s_q[5:1], d_bit};
                    if (enc_last) begin
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            s_q     <= '0;
            pre_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            pre_q   <= pre_d;
            err_q   <= err_d;
        end
    end

    // Block buffer: no reset needed, every fill overwrites the bits it later reads.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            buf_q[cnt_q[IDX_W-1:0]] <= in_bit;
        end
    end

    // Tail-biting wrap check: the state after the final shift equals the preload.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == ST_ENCODE && out_xfer && enc_last) begin
            assert (s_d == pre_q);
        end
    end

endmodule
